// File: rtl/pipe_hazard_unit.sv
// Hazard/flow controller for a 5-stage pipeline: EX forwarding selects, RAW/load-use stalls,
// redirect flushes, data-memory wait freeze with timeout FSM, saturating stall/flush counters.
module pipe_hazard_unit #(
  parameter int RA_W        = 5,
  parameter int FWD_EN      = 1,
  parameter int BR_STAGE    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [RA_W-1:0]  i_id_rs,
  input  logic [RA_W-1:0]  i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic [RA_W-1:0]  i_ex_rs,
  input  logic [RA_W-1:0]  i_ex_rt,
  input  logic [RA_W-1:0]  i_ex_rw,
  input  logic             i_ex_regwr,
  input  logic             i_ex_memtoreg,
  input  logic [RA_W-1:0]  i_mem_rw,
  input  logic             i_mem_regwr,
  input  logic [RA_W-1:0]  i_wb_rw,
  input  logic             i_wb_regwr,
  input  logic             i_redirect,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_idex_en,
  output logic             o_exmem_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_exmem_flush,
  output logic             o_memwb_flush,
  output logic             o_pc_sel_redir,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_RUN, ST_MWAIT, ST_ERR} state_t;

  state_t           r_state;
  logic [WC_W-1:0]  r_wait_cnt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_fz, w_hz, w_stall_ev, w_flush_ev;
  logic       w_rs_ex, w_rs_mem, w_rs_wb, w_rt_ex, w_rt_mem, w_rt_wb;
  logic [1:0] w_fwd_a, w_fwd_b;

  // r0 is hardwired zero, so it never produces a hazard or a forward
  function automatic logic f_match(input logic [RA_W-1:0] x, input logic [RA_W-1:0] y,
                                   input logic we);
    return we & (y != '0) & (x == y);
  endfunction

  function automatic logic [1:0] f_fwd(input logic [RA_W-1:0] src);
    if (FWD_EN == 0)                      return 2'b00;
    if (f_match(src, i_mem_rw, i_mem_regwr)) return 2'b10;
    if (f_match(src, i_wb_rw, i_wb_regwr))   return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    w_rs_ex  = i_id_use_rs & f_match(i_id_rs, i_ex_rw,  i_ex_regwr);
    w_rs_mem = i_id_use_rs & f_match(i_id_rs, i_mem_rw, i_mem_regwr);
    w_rs_wb  = i_id_use_rs & f_match(i_id_rs, i_wb_rw,  i_wb_regwr);
    w_rt_ex  = i_id_use_rt & f_match(i_id_rt, i_ex_rw,  i_ex_regwr);
    w_rt_mem = i_id_use_rt & f_match(i_id_rt, i_mem_rw, i_mem_regwr);
    w_rt_wb  = i_id_use_rt & f_match(i_id_rt, i_wb_rw,  i_wb_regwr);
    w_hz = 1'b0;
    if (FWD_EN != 0) w_hz = i_ex_memtoreg & (w_rs_ex | w_rt_ex);
    else             w_hz = w_rs_ex | w_rs_mem | w_rs_wb | w_rt_ex | w_rt_mem | w_rt_wb;
    w_fwd_a = f_fwd(i_ex_rs);
    w_fwd_b = f_fwd(i_ex_rt);
    w_fz = (r_state == ST_RUN & i_dmem_req & ~i_dmem_ready) |
           (r_state == ST_MWAIT & ~i_dmem_ready) | (r_state == ST_ERR);
    w_stall_ev = w_fz | (w_hz & ~i_redirect);
    w_flush_ev = i_redirect & ~w_fz;
  end

  // Priority: reset > freeze > redirect > hazard; a frozen redirect stays pending upstream
  always_comb begin
    o_pc_en        = 1'b1;
    o_ifid_en      = 1'b1;
    o_idex_en      = 1'b1;
    o_exmem_en     = 1'b1;
    o_ifid_flush   = 1'b0;
    o_idex_flush   = 1'b0;
    o_exmem_flush  = 1'b0;
    o_memwb_flush  = 1'b0;
    o_pc_sel_redir = 1'b0;
    o_fwd_a        = w_fwd_a;
    o_fwd_b        = w_fwd_b;
    if (i_rst) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_idex_en     = 1'b0;
      o_exmem_en    = 1'b0;
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
      o_memwb_flush = 1'b1;
      o_fwd_a       = 2'b00;
      o_fwd_b       = 2'b00;
    end else if (w_fz) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_idex_en     = 1'b0;
      o_exmem_en    = 1'b0;
      o_memwb_flush = 1'b1;
    end else if (i_redirect) begin
      o_pc_sel_redir = 1'b1;
      o_ifid_flush   = 1'b1;
      o_idex_flush   = 1'b1;
      o_exmem_flush  = (BR_STAGE == 3);
    end else if (w_hz) begin
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_idex_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_ev && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_ev && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      case (r_state)
        ST_RUN: begin
          if (i_dmem_req && !i_dmem_ready) begin
            r_state    <= ST_MWAIT;
            r_wait_cnt <= WC_W'(1);
          end
        end
        ST_MWAIT: begin
          if (i_dmem_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WC_W'(MEM_TIMEOUT)) begin
            r_state   <= ST_ERR;
            r_mem_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WC_W'(1);
          end
        end
        ST_ERR:  r_state <= ST_ERR;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign o_mem_err   = r_mem_err;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed scenarios plus randomized traffic against a reference
// model, run on a default instance and on a no-forwarding / EX-redirect / small-counter instance.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rw, mem_rw, wb_rw;
  logic       id_use_rs, id_use_rt, ex_regwr, ex_memtoreg, mem_regwr, wb_regwr;
  logic       redirect, dmem_req, dmem_ready;

  logic        pc0, ifid0, idex0, exmem0, fifid0, fidex0, fexmem0, fmemwb0, sel0, err0;
  logic [1:0]  fa0, fb0;
  logic [31:0] stall0, flush0;
  logic        pc1, ifid1, idex1, exmem1, fifid1, fidex1, fexmem1, fmemwb1, sel1, err1;
  logic [1:0]  fa1, fb1;
  logic [3:0]  stall1, flush1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit dut0 (
    .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs),
    .i_id_use_rt(id_use_rt), .i_ex_rs(ex_rs), .i_ex_rt(ex_rt), .i_ex_rw(ex_rw),
    .i_ex_regwr(ex_regwr), .i_ex_memtoreg(ex_memtoreg), .i_mem_rw(mem_rw),
    .i_mem_regwr(mem_regwr), .i_wb_rw(wb_rw), .i_wb_regwr(wb_regwr), .i_redirect(redirect),
    .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
    .o_pc_en(pc0), .o_ifid_en(ifid0), .o_idex_en(idex0), .o_exmem_en(exmem0),
    .o_ifid_flush(fifid0), .o_idex_flush(fidex0), .o_exmem_flush(fexmem0),
    .o_memwb_flush(fmemwb0), .o_pc_sel_redir(sel0), .o_fwd_a(fa0), .o_fwd_b(fb0),
    .o_mem_err(err0), .o_stall_cnt(stall0), .o_flush_cnt(flush0));

  pipe_hazard_unit #(.FWD_EN(0), .BR_STAGE(2), .MEM_TIMEOUT(3), .CNT_W(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs),
    .i_id_use_rt(id_use_rt), .i_ex_rs(ex_rs), .i_ex_rt(ex_rt), .i_ex_rw(ex_rw),
    .i_ex_regwr(ex_regwr), .i_ex_memtoreg(ex_memtoreg), .i_mem_rw(mem_rw),
    .i_mem_regwr(mem_regwr), .i_wb_rw(wb_rw), .i_wb_regwr(wb_regwr), .i_redirect(redirect),
    .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
    .o_pc_en(pc1), .o_ifid_en(ifid1), .o_idex_en(idex1), .o_exmem_en(exmem1),
    .o_ifid_flush(fifid1), .o_idex_flush(fidex1), .o_exmem_flush(fexmem1),
    .o_memwb_flush(fmemwb1), .o_pc_sel_redir(sel1), .o_fwd_a(fa1), .o_fwd_b(fb1),
    .o_mem_err(err1), .o_stall_cnt(stall1), .o_flush_cnt(flush1));

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, exmem_fl, memwb_fl, pc_sel, fwd_a, fwd_b}
  wire [12:0] ctl0 = {pc0, ifid0, idex0, exmem0, fifid0, fidex0, fexmem0, fmemwb0, sel0, fa0, fb0};
  wire [12:0] ctl1 = {pc1, ifid1, idex1, exmem1, fifid1, fidex1, fexmem1, fmemwb1, sel1, fa1, fb1};

  localparam logic [8:0] V_RST  = 9'b0000_1111_0;
  localparam logic [8:0] V_NORM = 9'b1111_0000_0;
  localparam logic [8:0] V_HZ   = 9'b0011_0100_0;
  localparam logic [8:0] V_RD3  = 9'b1111_1110_1;
  localparam logic [8:0] V_RD2  = 9'b1111_1100_1;
  localparam logic [8:0] V_FZ   = 9'b0000_0001_0;

  // reference model: per-instance configuration and abstract state
  bit     p_fwd [2] = '{1'b1, 1'b0};
  int     p_br  [2] = '{3, 2};
  int     p_to  [2] = '{15, 3};
  longint p_max [2] = '{64'hFFFF_FFFF, 64'd15};
  int     m_waited [2];
  bit     m_err    [2];
  longint m_stall  [2];
  longint m_flush  [2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    rst = 1'b0; redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rw = 0; mem_rw = 0; wb_rw = 0;
    id_use_rs = 0; id_use_rt = 0; ex_regwr = 0; ex_memtoreg = 0; mem_regwr = 0; wb_regwr = 0;
  endtask

  task automatic do_reset;
    clr_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic bit wr_hit(logic [4:0] src, logic [4:0] dst, logic we);
    return we && dst != 0 && dst == src;
  endfunction

  function automatic logic [1:0] mdl_fwd(int k, logic [4:0] src);
    if (rst || !p_fwd[k]) return 2'b00;
    if (wr_hit(src, mem_rw, mem_regwr)) return 2'b10;
    if (wr_hit(src, wb_rw, wb_regwr)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit mdl_hz(int k);
    logic [4:0] srcs [2];
    bit         used [2];
    bit         h = 0;
    srcs[0] = id_rs; srcs[1] = id_rt; used[0] = id_use_rs; used[1] = id_use_rt;
    for (int s = 0; s < 2; s++) begin
      if (!used[s]) continue;
      if (wr_hit(srcs[s], ex_rw, ex_regwr) && (!p_fwd[k] || ex_memtoreg)) h = 1;
      if (!p_fwd[k] && (wr_hit(srcs[s], mem_rw, mem_regwr) || wr_hit(srcs[s], wb_rw, wb_regwr)))
        h = 1;
    end
    return h;
  endfunction

  function automatic bit mdl_frozen(int k);
    if (m_err[k]) return 1;
    if (m_waited[k] > 0) return !dmem_ready;
    return dmem_req && !dmem_ready;
  endfunction

  function automatic logic [12:0] mdl_ctl(int k);
    logic [8:0] v;
    if (rst)                v = V_RST;
    else if (mdl_frozen(k)) v = V_FZ;
    else if (redirect)      v = (p_br[k] == 3) ? V_RD3 : V_RD2;
    else if (mdl_hz(k))     v = V_HZ;
    else                    v = V_NORM;
    return {v, mdl_fwd(k, ex_rs), mdl_fwd(k, ex_rt)};
  endfunction

  task automatic test_reset;
    clr_in();
    rst = 1; redirect = 1; dmem_req = 1; id_rs = 1; id_use_rs = 1; ex_rw = 1; ex_regwr = 1;
    ex_memtoreg = 1; ex_rs = 2; mem_rw = 2; mem_regwr = 1;
    @(negedge clk);
    tests++; if (ctl0 !== {V_RST, 4'b0000}) begin fails++; $display("FAIL reset_ctl0 got %b exp %b", ctl0, {V_RST, 4'b0000}); end
    tests++; if (ctl1 !== {V_RST, 4'b0000}) begin fails++; $display("FAIL reset_ctl1 got %b exp %b", ctl1, {V_RST, 4'b0000}); end
    tick();
    @(negedge clk);
    tests++; if (stall0 !== 0 || flush0 !== 0 || err0 !== 0) begin fails++; $display("FAIL reset_state0 stall=%0d flush=%0d err=%b exp 0 0 0", stall0, flush0, err0); end
    tests++; if (stall1 !== 0 || flush1 !== 0 || err1 !== 0) begin fails++; $display("FAIL reset_state1 stall=%0d flush=%0d err=%b exp 0 0 0", stall1, flush1, err1); end
  endtask

  task automatic test_load_use;
    do_reset();
    ex_rw = 1; ex_regwr = 1; ex_memtoreg = 1; id_rs = 1; id_use_rs = 1; id_rt = 3; id_use_rt = 1;
    @(negedge clk);
    tests++; if (ctl0 !== {V_HZ, 4'b0000}) begin fails++; $display("FAIL loaduse_stall0 got %b exp %b", ctl0, {V_HZ, 4'b0000}); end
    tests++; if (ctl1 !== {V_HZ, 4'b0000}) begin fails++; $display("FAIL loaduse_stall1 got %b exp %b", ctl1, {V_HZ, 4'b0000}); end
    tick();
    ex_rw = 0; ex_regwr = 0; ex_memtoreg = 0; mem_rw = 1; mem_regwr = 1;
    ex_rs = 1; ex_rt = 3; id_use_rs = 0; id_use_rt = 0;
    @(negedge clk);
    tests++; if (ctl0 !== {V_NORM, 4'b1000}) begin fails++; $display("FAIL loaduse_fwd0 got %b exp %b", ctl0, {V_NORM, 4'b1000}); end
    tests++; if (ctl1 !== {V_NORM, 4'b0000}) begin fails++; $display("FAIL loaduse_nofwd1 got %b exp %b", ctl1, {V_NORM, 4'b0000}); end
    tests++; if (stall0 !== 1) begin fails++; $display("FAIL loaduse_stallcnt got %0d exp 1", stall0); end
    tick();
    mem_regwr = 0; ex_rs = 0; ex_rt = 0; id_rs = 5; id_use_rs = 1; wb_rw = 5; wb_regwr = 1;
    @(negedge clk);
    tests++; if (ctl0 !== {V_NORM, 4'b0000}) begin fails++; $display("FAIL wbraw_fwd0 got %b exp %b", ctl0, {V_NORM, 4'b0000}); end
    tests++; if (ctl1 !== {V_HZ, 4'b0000}) begin fails++; $display("FAIL wbraw_stall1 got %b exp %b", ctl1, {V_HZ, 4'b0000}); end
  endtask

  task automatic test_forward;
    do_reset();
    ex_rs = 1; ex_rt = 1; mem_rw = 1; mem_regwr = 1; wb_rw = 1; wb_regwr = 1;
    @(negedge clk);
    tests++; if (ctl0 !== {V_NORM, 4'b1010}) begin fails++; $display("FAIL fwd_mem_wins got %b exp %b", ctl0, {V_NORM, 4'b1010}); end
    tests++; if (ctl1 !== {V_NORM, 4'b0000}) begin fails++; $display("FAIL fwd_disabled got %b exp %b", ctl1, {V_NORM, 4'b0000}); end
    tick();
    mem_rw = 2;
    @(negedge clk);
    tests++; if (ctl0 !== {V_NORM, 4'b0101}) begin fails++; $display("FAIL fwd_wb got %b exp %b", ctl0, {V_NORM, 4'b0101}); end
    tick();
    ex_rs = 0; mem_rw = 0; mem_regwr = 1; ex_rt = 2; wb_rw = 2; wb_regwr = 1;
    @(negedge clk);
    tests++; if (ctl0 !== {V_NORM, 4'b0001}) begin fails++; $display("FAIL fwd_r0 got %b exp %b", ctl0, {V_NORM, 4'b0001}); end
  endtask

  task automatic test_redirect_hz;
    do_reset();
    ex_rw = 1; ex_regwr = 1; ex_memtoreg = 1; id_rs = 1; id_use_rs = 1; redirect = 1;
    @(negedge clk);
    tests++; if (ctl0 !== {V_RD3, 4'b0000}) begin fails++; $display("FAIL redir_br3 got %b exp %b", ctl0, {V_RD3, 4'b0000}); end
    tests++; if (ctl1 !== {V_RD2, 4'b0000}) begin fails++; $display("FAIL redir_br2 got %b exp %b", ctl1, {V_RD2, 4'b0000}); end
    tick();
    clr_in();
    @(negedge clk);
    tests++; if (flush0 !== 1 || stall0 !== 0) begin fails++; $display("FAIL redir_cnt0 flush=%0d stall=%0d exp 1 0", flush0, stall0); end
    tests++; if (flush1 !== 1 || stall1 !== 0) begin fails++; $display("FAIL redir_cnt1 flush=%0d stall=%0d exp 1 0", flush1, stall1); end
  endtask

  task automatic test_mem_wait;
    do_reset();
    dmem_req = 1; redirect = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if (ctl0 !== {V_FZ, 4'b0000}) begin fails++; $display("FAIL wait_freeze c%0d got %b exp %b", c, ctl0, {V_FZ, 4'b0000}); end
      tick();
    end
    dmem_ready = 1;
    @(negedge clk);
    tests++; if (ctl0 !== {V_RD3, 4'b0000}) begin fails++; $display("FAIL wait_release0 got %b exp %b", ctl0, {V_RD3, 4'b0000}); end
    tests++; if (ctl1 !== {V_RD2, 4'b0000}) begin fails++; $display("FAIL wait_release1 got %b exp %b", ctl1, {V_RD2, 4'b0000}); end
    tests++; if (stall0 !== 3 || flush0 !== 0) begin fails++; $display("FAIL wait_cnt_pre stall=%0d flush=%0d exp 3 0", stall0, flush0); end
    tick();
    clr_in();
    @(negedge clk);
    tests++; if (stall0 !== 3 || flush0 !== 1) begin fails++; $display("FAIL wait_cnt0 stall=%0d flush=%0d exp 3 1", stall0, flush0); end
    tests++; if (stall1 !== 3 || flush1 !== 1) begin fails++; $display("FAIL wait_cnt1 stall=%0d flush=%0d exp 3 1", stall1, flush1); end
  endtask

  task automatic test_timeout;
    do_reset();
    dmem_req = 1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      tests++; if (ctl0 !== {V_FZ, 4'b0000}) begin fails++; $display("FAIL tmo_freeze c%0d got %b exp %b", c, ctl0, {V_FZ, 4'b0000}); end
      if (c == 15) begin
        tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL tmo_early_err got %b exp 0", err0); end
      end
      tick();
    end
    dmem_req = 0;
    @(negedge clk);
    tests++; if (err0 !== 1'b1) begin fails++; $display("FAIL tmo_err got %b exp 1", err0); end
    tests++; if (ctl0 !== {V_FZ, 4'b0000}) begin fails++; $display("FAIL tmo_err_hold got %b exp %b", ctl0, {V_FZ, 4'b0000}); end
    for (int c = 0; c < 4; c++) tick();
    @(negedge clk);
    tests++; if (stall0 !== 20) begin fails++; $display("FAIL tmo_stall0 got %0d exp 20", stall0); end
    tests++; if (stall1 !== 15 || err1 !== 1'b1) begin fails++; $display("FAIL tmo_sat1 stall=%0d err=%b exp 15 1", stall1, err1); end
    do_reset();
    dmem_req = 1;
    tick();
    tick();
    rst = 1;
    @(negedge clk);
    tests++; if (ctl0 !== {V_RST, 4'b0000}) begin fails++; $display("FAIL mwait_rst_ctl got %b exp %b", ctl0, {V_RST, 4'b0000}); end
    tick();
    clr_in();
    @(negedge clk);
    tests++; if (ctl0 !== {V_NORM, 4'b0000} || stall0 !== 0 || err0 !== 0) begin fails++; $display("FAIL mwait_rst_run ctl=%b stall=%0d err=%b exp %b 0 0", ctl0, stall0, err0, {V_NORM, 4'b0000}); end
  endtask

  task automatic test_random;
    int rdy_pct;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m_waited[k] = 0; m_err[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
    for (int n = 0; n < 900; n++) begin
      if (n % 150 == 0) rdy_pct = (n % 300 == 0) ? 80 : 35;
      rst = ($urandom_range(0, 59) == 0);
      redirect = ($urandom_range(0, 4) == 0);
      dmem_req = ($urandom_range(0, 3) == 0);
      dmem_ready = ($urandom_range(0, 99) < rdy_pct);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_rw = 5'($urandom_range(0, 3)); mem_rw = 5'($urandom_range(0, 3));
      wb_rw = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom); ex_regwr = 1'($urandom);
      ex_memtoreg = 1'($urandom); mem_regwr = 1'($urandom); wb_regwr = 1'($urandom);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic [12:0] c_act;
        longint      s_act, f_act;
        logic        e_act;
        bit          frz, stl;
        c_act = (k == 0) ? ctl0 : ctl1;
        s_act = (k == 0) ? longint'(stall0) : longint'(stall1);
        f_act = (k == 0) ? longint'(flush0) : longint'(flush1);
        e_act = (k == 0) ? err0 : err1;
        tests++; if (c_act !== mdl_ctl(k)) begin fails++; $display("FAIL rnd_ctl%0d n%0d got %b exp %b", k, n, c_act, mdl_ctl(k)); end
        tests++; if (s_act != m_stall[k] || f_act != m_flush[k]) begin fails++; $display("FAIL rnd_cnt%0d n%0d stall=%0d flush=%0d exp %0d %0d", k, n, s_act, f_act, m_stall[k], m_flush[k]); end
        tests++; if (e_act !== m_err[k]) begin fails++; $display("FAIL rnd_err%0d n%0d got %b exp %b", k, n, e_act, m_err[k]); end
        // advance the model across the coming edge
        frz = mdl_frozen(k);
        stl = frz || (mdl_hz(k) && !redirect);
        if (rst) begin
          m_waited[k] = 0; m_err[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end else begin
          if (stl && m_stall[k] < p_max[k]) m_stall[k]++;
          if (redirect && !frz && m_flush[k] < p_max[k]) m_flush[k]++;
          if (!m_err[k]) begin
            if (m_waited[k] > 0) begin
              if (dmem_ready) m_waited[k] = 0;
              else if (m_waited[k] == p_to[k]) m_err[k] = 1;
              else m_waited[k]++;
            end else if (dmem_req && !dmem_ready) begin
              m_waited[k] = 1;
            end
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    clr_in();
    test_reset();
    test_load_use();
    test_forward();
    test_redirect_hz();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
